// File: rtl/fp_adder_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fp_arb_pkg
// Shared definitions for the two-requester floating-point adder arbiter:
// the controller state enum, the requester count, the default datapath
// width and WAIT timeout, and small index helpers used by the arbiter and
// its round-robin grant block.
// Ports: none (package).
// ---------------------------------------------------------------------------
package fp_arb_pkg;

   localparam int NUM_REQ         = 2;
   localparam int IDX_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int DEFAULT_WIDTH   = 64;
   localparam int DEFAULT_TIMEOUT = 255;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT    = 2'd2,
      RESPOND = 2'd3
   } arb_state_t;

   // Requester index that follows idx, wrapping back to requester 0.
   function automatic logic [IDX_W-1:0] next_index(input logic [IDX_W-1:0] idx);
      if (int'(idx) == NUM_REQ - 1) begin
         return '0;
      end
      return idx + 1'b1;
   endfunction

   // One-hot requester vector with only bit idx set.
   function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [NUM_REQ-1:0] vec;
      vec      = '0;
      vec[idx] = 1'b1;
      return vec;
   endfunction

endpackage

// File: rtl/fp_adder_arbiter_if.sv
// ---------------------------------------------------------------------------
// fp_adder_arbiter_if
// Requester-side bus of the adder arbiter: per-requester request handshake
// with packed operands, and per-requester response handshake sharing one
// result/error pair.
//   req_valid / req_ready  : request handshake, one bit per requester
//   req_a / req_b          : packed operands, slice i belongs to requester i
//   rsp_valid / rsp_ready  : response handshake, one bit per requester
//   rsp_sum / rsp_err      : result and timeout flag, qualified by rsp_valid
// Modports: master = requesters, slave = arbiter.
// ---------------------------------------------------------------------------
interface fp_adder_arbiter_if
   import fp_arb_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);

   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ*WIDTH-1:0] req_a;
   logic [NUM_REQ*WIDTH-1:0] req_b;
   logic [NUM_REQ-1:0]       rsp_valid;
   logic [NUM_REQ-1:0]       rsp_ready;
   logic [WIDTH-1:0]         rsp_sum;
   logic                     rsp_err;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_sum, rsp_err
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_sum, rsp_err
   );

endinterface

// File: rtl/fp_rr_grant.sv
// ---------------------------------------------------------------------------
// fp_rr_grant
// Round-robin grant for the arbiter. Holds the priority pointer and picks
// the first valid requester at or after it.
//   clk, rst    : clock and asynchronous active-high reset
//   req         : per-requester valid
//   advance     : a grant was taken this cycle, move the pointer
//   grant       : one-hot winner (all zero when nobody requests)
//   grant_idx   : binary index of the winner
//   grant_valid : at least one requester is valid
// ---------------------------------------------------------------------------
module fp_rr_grant
   import fp_arb_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               advance,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_valid
);

   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] cand;

   // Scan from the farthest offset back to the pointer so that the closest
   // valid requester to the pointer is written last and therefore wins.
   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      cand        = '0;
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
         cand = IDX_W'((int'(ptr) + off) % NUM_REQ);
         if (req[cand]) begin
            grant       = onehot(cand);
            grant_idx   = cand;
            grant_valid = 1'b1;
         end
      end
   end

   // After a grant the requester following the winner becomes favored, so a
   // requester that keeps asking cannot starve the other one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (advance) begin
         ptr <= next_index(grant_idx);
      end
   end

endmodule

// File: rtl/fp_adder_arbiter.sv
// ---------------------------------------------------------------------------
// fp_adder_arbiter
// Shares one multi-cycle floating-point adder between two requesters.
// A round-robin winner is accepted in IDLE, its operands are launched to
// the adder with a one-cycle start pulse, the result (or a timeout error)
// is returned to that requester, and the block goes back to IDLE once the
// requester accepts the response.
//   clk, rst          : clock and asynchronous active-high reset
//   bus (slave)       : requester request/response handshakes
//   add_start         : one-cycle launch pulse to the adder
//   add_a, add_b      : adder operands, held from ISSUE until WAIT ends
//   add_done, add_sum : adder completion pulse and result
//   busy              : high whenever the controller is not IDLE
// ---------------------------------------------------------------------------
module fp_adder_arbiter
   import fp_arb_pkg::*;
#(
   parameter int WIDTH   = DEFAULT_WIDTH,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic             clk,
   input  logic             rst,
   fp_adder_arbiter_if.slave bus,
   output logic             add_start,
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   input  logic             add_done,
   input  logic [WIDTH-1:0] add_sum,
   output logic             busy
);

   localparam int               CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   arb_state_t state;

   logic [IDX_W-1:0]              grant_q;
   logic [CNT_W-1:0]              cnt;
   logic [NUM_REQ-1:0]            rsp_valid_q;
   logic [WIDTH-1:0]              rsp_sum_q;
   logic                          rsp_err_q;

   logic [NUM_REQ-1:0]            rr_grant;
   logic [IDX_W-1:0]              rr_idx;
   logic                          rr_valid;
   logic                          take;
   logic                          in_idle;
   logic [NUM_REQ-1:0][WIDTH-1:0] req_a_arr;
   logic [NUM_REQ-1:0][WIDTH-1:0] req_b_arr;

   assign req_a_arr = bus.req_a;
   assign req_b_arr = bus.req_b;

   fp_rr_grant u_rr_grant (
      .clk         (clk),
      .rst         (rst),
      .req         (bus.req_valid),
      .advance     (take),
      .grant       (rr_grant),
      .grant_idx   (rr_idx),
      .grant_valid (rr_valid)
   );

   // Acceptance is offered only in IDLE and only to the round-robin winner.
   // It is also held off while reset is asserted so no requester can see a
   // handshake that the controller is not going to capture.
   assign in_idle       = (state == IDLE) && !rst;
   assign bus.req_ready = in_idle ? rr_grant : '0;
   assign take          = in_idle && rr_valid;

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_sum   = rsp_sum_q;
   assign bus.rsp_err   = rsp_err_q;

   // Controller FSM with all adder/response outputs registered.
   // WAIT lasts at most TIMEOUT cycles (counter values 0..TIMEOUT-1); a done
   // pulse in the final WAIT cycle still beats the timeout. add_done outside
   // WAIT is never looked at, so a pulse left over from an aborted operation
   // cannot leak into a later one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         grant_q     <= '0;
         cnt         <= '0;
         add_start   <= 1'b0;
         add_a       <= '0;
         add_b       <= '0;
         rsp_valid_q <= '0;
         rsp_sum_q   <= '0;
         rsp_err_q   <= 1'b0;
         busy        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (take) begin
                  state     <= ISSUE;
                  grant_q   <= rr_idx;
                  add_start <= 1'b1;
                  add_a     <= req_a_arr[rr_idx];
                  add_b     <= req_b_arr[rr_idx];
                  cnt       <= '0;
                  busy      <= 1'b1;
               end
            end
            ISSUE: begin
               add_start <= 1'b0;
               cnt       <= '0;
               state     <= WAIT;
            end
            WAIT: begin
               if (add_done || (cnt == CNT_LAST)) begin
                  state       <= RESPOND;
                  rsp_valid_q <= onehot(grant_q);
                  rsp_sum_q   <= add_done ? add_sum : '0;
                  rsp_err_q   <= !add_done;
                  add_a       <= '0;
                  add_b       <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RESPOND: begin
               if (bus.rsp_ready[grant_q]) begin
                  state       <= IDLE;
                  rsp_valid_q <= '0;
                  rsp_sum_q   <= '0;
                  rsp_err_q   <= 1'b0;
                  cnt         <= '0;
                  busy        <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp_adder_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fp_adder_arbiter
// Self-checking bench for fp_adder_arbiter with a behavioural adder model
// (configurable latency, or never completing) and a requester-level model of
// round-robin arbitration, expected result and expected response cycle.
// ---------------------------------------------------------------------------
module tb_fp_adder_arbiter;

   localparam int TB_WIDTH   = 64;
   localparam int TB_TIMEOUT = 8;

   logic                clk = 1'b0;
   logic                rst;
   logic                add_start;
   logic [TB_WIDTH-1:0] add_a;
   logic [TB_WIDTH-1:0] add_b;
   logic                add_done = 1'b0;
   logic [TB_WIDTH-1:0] add_sum  = '0;
   logic                busy;

   int checks;
   int failures;

   // Adder model controls and state.
   int                  adder_latency = 1;
   bit                  adder_enable  = 1'b0;
   bit                  use_fixed     = 1'b0;
   logic [TB_WIDTH-1:0] fixed_sum     = '0;
   int                  timer         = 0;
   int                  start_count   = 0;
   logic [TB_WIDTH-1:0] pend_sum      = '0;

   fp_adder_arbiter_if #(.WIDTH(TB_WIDTH)) bus ();

   fp_adder_arbiter #(.WIDTH(TB_WIDTH), .TIMEOUT(TB_TIMEOUT)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .add_start (add_start),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_done  (add_done),
      .add_sum   (add_sum),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Adder model: a start seen in cycle n produces a one-cycle done in
   // cycle n+latency carrying a+b (or a fixed value). add_sum carries junk
   // whenever done is low.
   always begin
      @(posedge clk);
      #1;
      add_done = 1'b0;
      add_sum  = {$urandom, $urandom};
      if (timer > 0) begin
         timer--;
         if (timer == 0) begin
            add_done = 1'b1;
            add_sum  = pend_sum;
         end
      end
      if (add_start === 1'b1) begin
         start_count++;
         if (adder_enable) begin
            timer    = adder_latency;
            pend_sum = use_fixed ? fixed_sum : add_a + add_b;
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.req_valid = '0;
      bus.rsp_ready = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Reset forces every output low even with both requesters asking; after
   // release requester 0 is favored.
   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.req_valid = 2'b11;
      #1;
      checks++;
      if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, add_start, busy, bus.rsp_sum, add_a, add_b} !== '0) begin
         failures++;
         $display("[TB] FAIL reset_outputs: req_ready=%b rsp_valid=%b err=%b start=%b busy=%b sum=%h a=%h b=%h required all zero",
                  bus.req_ready, bus.rsp_valid, bus.rsp_err, add_start, busy, bus.rsp_sum, add_a, add_b);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (bus.req_ready !== 2'b01) begin
         failures++;
         $display("[TB] FAIL reset_first_grant: got %b expected 01", bus.req_ready);
      end
      bus.req_valid = 2'b00;
   endtask

   // Single request on requester 0 with a 3-cycle adder.
   task automatic test_single();
      int cyc;
      int starts0;
      adder_enable  = 1'b1;
      adder_latency = 3;
      use_fixed     = 1'b1;
      fixed_sum     = 64'h40400000;
      starts0       = start_count;
      @(negedge clk);
      bus.req_valid = 2'b01;
      bus.req_a     = {64'h0, 64'h3F800000};
      bus.req_b     = {64'h0, 64'h40000000};
      #1;
      checks++;
      if (bus.req_ready !== 2'b01) begin
         failures++;
         $display("[TB] FAIL single_req_ready: got %b expected 01", bus.req_ready);
      end
      @(negedge clk);
      bus.req_valid = 2'b00;
      checks++;
      if ({add_start, busy, add_a, add_b} !== {1'b1, 1'b1, 64'h3F800000, 64'h40000000}) begin
         failures++;
         $display("[TB] FAIL single_issue: start=%b busy=%b a=%h b=%h expected 1 1 3f800000 40000000",
                  add_start, busy, add_a, add_b);
      end
      cyc = 1;
      while (bus.rsp_valid === 2'b00 && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (cyc != 5) begin
         failures++;
         $display("[TB] FAIL single_latency: got cycle %0d expected 5", cyc);
      end
      checks++;
      if ({bus.rsp_valid, bus.rsp_sum, bus.rsp_err} !== {2'b01, 64'h40400000, 1'b0}) begin
         failures++;
         $display("[TB] FAIL single_response: valid=%b sum=%h err=%b expected 01 40400000 0",
                  bus.rsp_valid, bus.rsp_sum, bus.rsp_err);
      end
      checks++;
      if (start_count - starts0 != 1) begin
         failures++;
         $display("[TB] FAIL single_start_pulses: got %0d expected 1", start_count - starts0);
      end
      bus.rsp_ready = 2'b01;
      @(negedge clk);
      bus.rsp_ready = 2'b00;
      checks++;
      if ({bus.rsp_valid, busy, add_a} !== '0) begin
         failures++;
         $display("[TB] FAIL single_return_idle: valid=%b busy=%b a=%h expected all zero", bus.rsp_valid, busy, add_a);
      end
   endtask

   // Pass 0: adder never finishes -> error after TIMEOUT WAIT cycles.
   // Pass 1: done lands on the last WAIT cycle -> done wins, no error.
   task automatic test_timeout();
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] esum;
      logic        eerr;
      int          cyc;
      for (int k = 0; k < 2; k++) begin
         a             = {$urandom, $urandom};
         b             = {$urandom, $urandom};
         adder_enable  = (k == 1);
         adder_latency = TB_TIMEOUT;
         use_fixed     = 1'b0;
         esum          = (k == 1) ? a + b : 64'h0;
         eerr          = (k == 0);
         @(negedge clk);
         bus.req_valid = 2'b10;
         bus.req_a     = {a, 64'h0};
         bus.req_b     = {b, 64'h0};
         @(negedge clk);
         bus.req_valid = 2'b00;
         cyc = 1;
         while (bus.rsp_valid === 2'b00 && cyc < 40) begin
            checks++;
            if (add_a !== a || add_b !== b) begin
               failures++;
               $display("[TB] FAIL timeout_operands_held: a=%h b=%h expected %h %h", add_a, add_b, a, b);
            end
            @(negedge clk);
            cyc++;
         end
         checks++;
         if (cyc != TB_TIMEOUT + 2) begin
            failures++;
            $display("[TB] FAIL timeout_latency pass %0d: got cycle %0d expected %0d", k, cyc, TB_TIMEOUT + 2);
         end
         checks++;
         if ({bus.rsp_valid, bus.rsp_sum, bus.rsp_err} !== {2'b10, esum, eerr}) begin
            failures++;
            $display("[TB] FAIL timeout_response pass %0d: valid=%b sum=%h err=%b expected 10 %h %b",
                     k, bus.rsp_valid, bus.rsp_sum, bus.rsp_err, esum, eerr);
         end
         bus.rsp_ready = 2'b10;
         @(negedge clk);
         bus.rsp_ready = 2'b00;
         checks++;
         if ({bus.rsp_valid, busy} !== '0) begin
            failures++;
            $display("[TB] FAIL timeout_return_idle: valid=%b busy=%b expected 0", bus.rsp_valid, busy);
         end
      end
   endtask

   // Response held off for 10 cycles (only the other requester's ready is
   // high) while both requesters keep asking.
   task automatic test_backpressure();
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] esum;
      int          cyc;
      a             = {$urandom, $urandom};
      b             = {$urandom, $urandom};
      esum          = a + b;
      adder_enable  = 1'b1;
      adder_latency = 2;
      use_fixed     = 1'b0;
      @(negedge clk);
      bus.req_valid = 2'b10;
      bus.req_a     = {a, 64'h0};
      bus.req_b     = {b, 64'h0};
      @(negedge clk);
      bus.req_valid = 2'b00;
      cyc = 1;
      while (bus.rsp_valid === 2'b00 && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (cyc != 4) begin
         failures++;
         $display("[TB] FAIL backpressure_latency: got cycle %0d expected 4", cyc);
      end
      bus.req_valid = 2'b11;
      bus.rsp_ready = 2'b01;
      for (int h = 0; h < 10; h++) begin
         #1;
         checks++;
         if ({bus.rsp_valid, bus.rsp_sum, bus.rsp_err, bus.req_ready, busy} !== {2'b10, esum, 1'b0, 2'b00, 1'b1}) begin
            failures++;
            $display("[TB] FAIL backpressure_hold cycle %0d: valid=%b sum=%h err=%b req_ready=%b busy=%b expected 10 %h 0 00 1",
                     h, bus.rsp_valid, bus.rsp_sum, bus.rsp_err, bus.req_ready, busy, esum);
         end
         @(negedge clk);
      end
      bus.req_valid = 2'b00;
      bus.rsp_ready = 2'b10;
      @(negedge clk);
      bus.rsp_ready = 2'b00;
      checks++;
      if ({bus.rsp_valid, busy} !== '0) begin
         failures++;
         $display("[TB] FAIL backpressure_release: valid=%b busy=%b expected 0", bus.rsp_valid, busy);
      end
   endtask

   // Reset pulsed while WAITing; the adder's late done must be ignored and
   // the next request must complete normally from requester 0's priority.
   task automatic test_reset_in_wait();
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] esum;
      int          cyc;
      adder_enable  = 1'b1;
      adder_latency = 6;
      use_fixed     = 1'b0;
      @(negedge clk);
      bus.req_valid = 2'b01;
      bus.req_a     = {64'h0, {$urandom, $urandom}};
      bus.req_b     = {64'h0, {$urandom, $urandom}};
      @(negedge clk);
      bus.req_valid = 2'b00;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, add_start, busy, bus.rsp_sum, add_a, add_b} !== '0) begin
         failures++;
         $display("[TB] FAIL wait_reset_outputs: valid=%b start=%b busy=%b a=%h b=%h required all zero",
                  bus.rsp_valid, add_start, busy, add_a, add_b);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         checks++;
         if ({bus.rsp_valid, busy, add_start, add_a} !== '0) begin
            failures++;
            $display("[TB] FAIL wait_reset_late_done cycle %0d: valid=%b busy=%b start=%b a=%h expected all zero",
                     c, bus.rsp_valid, busy, add_start, add_a);
         end
         @(negedge clk);
      end
      a             = {$urandom, $urandom};
      b             = {$urandom, $urandom};
      esum          = a + b;
      adder_latency = 2;
      bus.req_valid = 2'b11;
      bus.req_a     = {64'h0, a};
      bus.req_b     = {64'h0, b};
      #1;
      checks++;
      if (bus.req_ready !== 2'b01) begin
         failures++;
         $display("[TB] FAIL wait_reset_pointer: got %b expected 01", bus.req_ready);
      end
      @(negedge clk);
      bus.req_valid = 2'b00;
      cyc = 1;
      while (bus.rsp_valid === 2'b00 && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (cyc != 4 || {bus.rsp_valid, bus.rsp_sum, bus.rsp_err} !== {2'b01, esum, 1'b0}) begin
         failures++;
         $display("[TB] FAIL wait_reset_recovery: cycle=%0d valid=%b sum=%h err=%b expected 4 01 %h 0",
                  cyc, bus.rsp_valid, bus.rsp_sum, bus.rsp_err, esum);
      end
      bus.rsp_ready = 2'b01;
      @(negedge clk);
      bus.rsp_ready = 2'b00;
   endtask

   // Requester-level model: each requester holds at most one pending
   // operation; when both are pending the favored one wins and the other
   // becomes favored. The result is a+b if the adder answers within TIMEOUT
   // WAIT cycles, otherwise 0 with the error flag.
   task automatic run_arbitration(input int n, input bit force_both, input bit check_alternate);
      logic [63:0] qa [2];
      logic [63:0] qb [2];
      logic [1:0]  pend;
      logic [63:0] esum;
      logic        eerr;
      int          favored;
      int          w;
      int          lat;
      int          hold;
      int          cyc;
      int          r;
      do_reset();
      favored      = 0;
      pend         = 2'b00;
      use_fixed    = 1'b0;
      adder_enable = 1'b1;
      @(negedge clk);
      for (int t = 0; t < n; t++) begin
         for (int i = 0; i < 2; i++) begin
            if (!pend[i] && (force_both || $urandom_range(0, 1) == 1)) begin
               pend[i] = 1'b1;
               qa[i]   = {$urandom, $urandom};
               qb[i]   = {$urandom, $urandom};
            end
         end
         if (pend == 2'b00) begin
            r       = $urandom_range(0, 1);
            pend[r] = 1'b1;
            qa[r]   = {$urandom, $urandom};
            qb[r]   = {$urandom, $urandom};
         end
         bus.req_valid = pend;
         bus.req_a     = {qa[1], qa[0]};
         bus.req_b     = {qb[1], qb[0]};
         w             = pend[favored] ? favored : 1 - favored;
         lat           = $urandom_range(1, TB_TIMEOUT + 2);
         adder_latency = lat;
         eerr          = (lat > TB_TIMEOUT);
         esum          = eerr ? 64'h0 : qa[w] + qb[w];
         #1;
         checks++;
         if (bus.req_ready !== (2'b01 << w)) begin
            failures++;
            $display("[TB] FAIL arb_grant txn %0d: req_ready=%b expected winner %0d", t, bus.req_ready, w);
         end
         if (check_alternate) begin
            checks++;
            if (w != t % 2) begin
               failures++;
               $display("[TB] FAIL arb_alternate txn %0d: winner %0d expected %0d", t, w, t % 2);
            end
         end
         @(negedge clk);
         pend[w]       = 1'b0;
         favored       = 1 - w;
         bus.req_valid = pend;
         cyc = 1;
         while (bus.rsp_valid === 2'b00 && cyc < 40) begin
            checks++;
            if ({bus.req_ready, busy, add_a, add_b} !== {2'b00, 1'b1, qa[w], qb[w]}) begin
               failures++;
               $display("[TB] FAIL arb_busy txn %0d: req_ready=%b busy=%b a=%h b=%h expected 00 1 %h %h",
                        t, bus.req_ready, busy, add_a, add_b, qa[w], qb[w]);
            end
            @(negedge clk);
            cyc++;
         end
         checks++;
         if (cyc != (eerr ? TB_TIMEOUT + 2 : lat + 2)) begin
            failures++;
            $display("[TB] FAIL arb_latency txn %0d: got cycle %0d expected %0d (adder latency %0d)",
                     t, cyc, eerr ? TB_TIMEOUT + 2 : lat + 2, lat);
         end
         hold = $urandom_range(0, 3);
         for (int h = 0; h <= hold; h++) begin
            checks++;
            if ({bus.rsp_valid, bus.rsp_sum, bus.rsp_err} !== {2'b01 << w, esum, eerr}) begin
               failures++;
               $display("[TB] FAIL arb_response txn %0d: valid=%b sum=%h err=%b expected %b %h %b",
                        t, bus.rsp_valid, bus.rsp_sum, bus.rsp_err, 2'b01 << w, esum, eerr);
            end
            if (h < hold) begin
               bus.rsp_ready = 2'b01 << (1 - w);
               @(negedge clk);
            end
         end
         bus.rsp_ready = (2'b01 << w) | (($urandom_range(0, 1) == 1) ? (2'b01 << (1 - w)) : 2'b00);
         @(negedge clk);
         bus.rsp_ready = 2'b00;
         checks++;
         if ({bus.rsp_valid, busy} !== '0) begin
            failures++;
            $display("[TB] FAIL arb_return_idle txn %0d: valid=%b busy=%b expected 0", t, bus.rsp_valid, busy);
         end
      end
      bus.req_valid = 2'b00;
   endtask

   task automatic test_back_to_back();
      run_arbitration(4, 1'b1, 1'b1);
   endtask

   task automatic test_random();
      run_arbitration(30, 1'b0, 1'b0);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      checks        = 0;
      failures      = 0;
      rst           = 1'b1;
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = '0;
      repeat (2) @(negedge clk);
      test_reset();
      test_single();
      test_timeout();
      test_backpressure();
      test_reset_in_wait();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
